// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and bridge state encoding.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } bridge_state_t;

    function automatic logic is_wait_state(input bridge_state_t s);
        return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
               (s == ST_RD_REQ) || (s == ST_RD_DATA);
    endfunction

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite signal bundle with master and slave views.
interface axi4_lite #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axilite_timeout_ctr.sv
// Wait-cycle counter: expired is high on the TIMEOUT_CYCLES-th enabled cycle after a clear.
// Holds at the terminal count so it never wraps back to zero while still enabled.
module axilite_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/axilite_master_bridge.sv
// Register command -> single AXI4-Lite transaction; rsp_valid 3 cycles after accept on a zero-wait slave.
// One command in flight: cmd_ready only in IDLE, response held until rsp_ready; a stuck slave aborts via timeout.
module axilite_master_bridge
    import axi4lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    axi4_lite.master                axi
);
    bridge_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    resp_t                   rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic tmo_clr;
    logic tmo_en;
    logic tmo_expired;
    logic aw_done;
    logic w_done;

    axilite_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign aw_done = !awvalid_q || axi.awready;
    assign w_done  = !wvalid_q  || axi.wready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d        = cmd_addr;
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; leave only once both are done.
                if (awvalid_q && axi.awready) awvalid_d = 1'b0;
                if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d = ST_WR_RESP;
                end else if (tmo_expired) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                end
            end
            ST_WR_RESP: begin
                if (axi.bvalid) begin
                    rsp_resp_d  = resp_t'(axi.bresp);
                    rsp_rdata_d = '0;
                    state_d     = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end else if (tmo_expired) begin
                    arvalid_d = 1'b0;
                end
            end
            ST_RD_DATA: begin
                if (axi.rvalid) begin
                    rsp_resp_d  = resp_t'(axi.rresp);
                    rsp_rdata_d = axi.rdata;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real handshake in the expiring cycle wins; otherwise abort with SLVERR.
        if (tmo_expired && (state_d == state_q)) begin
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            state_d       = ST_RESP;
        end

        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        tmo_clr     = (state_d != state_q);
        tmo_en      = is_wait_state(state_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = 3'b000;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = (state_q == ST_WR_RESP);
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = 3'b000;
    assign axi.rready  = (state_q == ST_RD_DATA);
endmodule

// File: tb/tb_axilite_master_bridge.sv
// Bench for axilite_master_bridge: delay-programmable memory slave, directed cases and a random command mix.
module tb_axilite_master_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    always #5 clk = ~clk;

    axi4_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axilite_master_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .axi(axi)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave: 256-word memory, SLVERR at or above 0x400 ----------------
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit hang = 1'b0;
    logic [31:0] smem [256];
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_cnt = 0, r_cnt = 0;
    logic aw_got = 1'b0, w_got = 1'b0, bvalid_r = 1'b0, rvalid_r = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, rdata_r = '0;
    logic [3:0] s_wstrb = '0;
    logic [1:0] bresp_r = '0, rresp_r = '0;
    logic aw_now, w_now;
    logic [31:0] wa, wd;
    logic [3:0] ws;

    assign axi.awready = !hang && axi.awvalid && (aw_wait >= aw_dly);
    assign axi.wready  = !hang && axi.wvalid  && (w_wait  >= w_dly);
    assign axi.arready = !hang && axi.arvalid && (ar_wait >= ar_dly);
    assign axi.bvalid  = bvalid_r;
    assign axi.bresp   = bresp_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rdata   = rdata_r;
    assign axi.rresp   = rresp_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
            bresp_r <= '0; rresp_r <= '0; rdata_r <= '0;
            for (int i = 0; i < 256; i++) smem[i] <= '0;
        end else begin
            aw_wait <= (axi.awvalid && !axi.awready) ? aw_wait + 1 : 0;
            w_wait  <= (axi.wvalid  && !axi.wready)  ? w_wait + 1  : 0;
            ar_wait <= (axi.arvalid && !axi.arready) ? ar_wait + 1 : 0;
            aw_now = aw_got || (axi.awvalid && axi.awready);
            w_now  = w_got  || (axi.wvalid && axi.wready);
            wa = aw_got ? s_awaddr : axi.awaddr;
            wd = w_got ? s_wdata : axi.wdata;
            ws = w_got ? s_wstrb : axi.wstrb;
            if (axi.awvalid && axi.awready) begin s_awaddr <= axi.awaddr; aw_got <= 1'b1; end
            if (axi.wvalid && axi.wready) begin s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; w_got <= 1'b1; end
            if (aw_now && w_now) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                if (wa < 32'h400) begin
                    for (int l = 0; l < 4; l++)
                        if (ws[l]) smem[wa[9:2]][8*l +: 8] <= wd[8*l +: 8];
                    bresp_r <= 2'b00;
                end else begin
                    bresp_r <= 2'b10;
                end
                if (b_dly == 0) bvalid_r <= 1'b1; else b_cnt <= b_dly;
            end
            if (b_cnt > 0) begin b_cnt <= b_cnt - 1; if (b_cnt == 1) bvalid_r <= 1'b1; end
            if (bvalid_r && axi.bready) bvalid_r <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                s_araddr <= axi.araddr;
                rdata_r  <= (axi.araddr < 32'h400) ? smem[axi.araddr[9:2]] : 32'h0;
                rresp_r  <= (axi.araddr < 32'h400) ? 2'b00 : 2'b10;
                if (r_dly == 0) rvalid_r <= 1'b1; else r_cnt <= r_dly;
            end
            if (r_cnt > 0) begin r_cnt <= r_cnt - 1; if (r_cnt == 1) rvalid_r <= 1'b1; end
            if (rvalid_r && axi.rready) rvalid_r <= 1'b0;
        end
    end

    // ---------------- bus monitor: handshake counts and stability ----------------
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, ar_hi = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, prot_err = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awa = '0, p_wd = '0, p_ara = '0;
    logic [3:0] p_ws = '0;

    always @(posedge clk) begin
        if (axi.awvalid && axi.awready) begin aw_hs <= aw_hs + 1; aw_hs_cyc <= cyc; end
        if (axi.wvalid && axi.wready) begin w_hs <= w_hs + 1; w_hs_cyc <= cyc; end
        if (axi.bvalid && axi.bready) b_hs <= b_hs + 1;
        if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
        if (axi.rvalid && axi.rready) r_hs <= r_hs + 1;
        if (axi.arvalid) ar_hi <= ar_hi + 1;
        if (rst_n && !hang) begin
            if ((p_awv && !p_awr && (!axi.awvalid || axi.awaddr !== p_awa)) ||
                (p_wv && !p_wr && (!axi.wvalid || axi.wdata !== p_wd || axi.wstrb !== p_ws)) ||
                (p_arv && !p_arr && (!axi.arvalid || axi.araddr !== p_ara)) ||
                (axi.bready && axi.rready) || (axi.awvalid && axi.arvalid) ||
                (axi.awprot !== 3'b000) || (axi.arprot !== 3'b000))
                prot_err <= prot_err + 1;
        end
        p_awv <= axi.awvalid; p_awr <= axi.awready; p_awa <= axi.awaddr;
        p_wv <= axi.wvalid; p_wr <= axi.wready; p_wd <= axi.wdata; p_ws <= axi.wstrb;
        p_arv <= axi.arvalid; p_arr <= axi.arready; p_ara <= axi.araddr;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];
    logic        to_after_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] erd, output logic [1:0] ers);
        erd = '0;
        ers = (a < 32'h400) ? 2'b00 : 2'b10;
        if (a < 32'h400) begin
            if (w) begin
                for (int l = 0; l < 4; l++)
                    if (s[l]) ref_mem[a[9:2]][8*l +: 8] = d[8*l +: 8];
            end else begin
                erd = ref_mem[a[9:2]];
            end
        end
    endtask

    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        to_after_acc = rsp_timeout;
        chk("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic get_rsp(input int acc, input int hold, output int lat,
                           output logic [31:0] rd, output logic [1:0] rs, output logic to);
        int k = 0;
        bit bad = 1'b0;
        while (rsp_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("rsp_valid_seen", rsp_valid, 1);
        lat = cyc - acc; rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        repeat (hold) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs ||
                rsp_timeout !== to || cmd_ready !== 1'b0) bad = 1'b1;
        end
        chk("rsp_stable", bad, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
    endtask

    task automatic do_txn(input string tag, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int hold);
        logic [31:0] erd, rd;
        logic [1:0]  ers, rs;
        logic        to;
        int acc, lat, elat;
        elat = w ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
        model(w, a, d, s, erd, ers);
        send_cmd(w, a, d, s, acc);
        get_rsp(acc, hold, lat, rd, rs, to);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_resp"}, rs, ers);
        chk({tag, "_timeout"}, to, 0);
    endtask

    initial begin
        int acc, lat, aw0, w0, b0, ar0, r0;
        logic [31:0] rd, d, a;
        logic [1:0] rs;
        logic to;
        bit w, seen;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_axi_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("rst_axi_addr", axi.awaddr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        // zero-wait write then read-back
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        do_txn("wr08", 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0);
        chk("wr08_mem", smem[2], 32'hDEADBEEF);
        chk("wr08_aw_count", aw_hs - aw0, 1);
        chk("wr08_w_count", w_hs - w0, 1);
        chk("wr08_b_count", b_hs - b0, 1);
        chk("wr08_awaddr", s_awaddr, 32'h08);
        do_txn("rd08", 1'b0, 32'h08, 32'h0, 4'h0, 0);
        chk("rd08_araddr", s_araddr, 32'h08);

        // W accepted three cycles before AW
        aw_dly = 3; b0 = b_hs;
        do_txn("wr_wfirst", 1'b1, 32'h10, $urandom, 4'hF, 0);
        chk("wr_wfirst_order", aw_hs_cyc - w_hs_cyc, 3);
        chk("wr_wfirst_b_count", b_hs - b0, 1);
        aw_dly = 0;

        // out-of-range read answered with SLVERR by the slave
        do_txn("rd400", 1'b0, 32'h400, 32'h0, 4'h0, 0);

        // random mix of reads/writes, strobes, slave delays and response backpressure
        for (int n = 0; n < 40; n++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 63) * 4)
                                            : 32'($urandom_range(0, 15) * 4);
            d = $urandom;
            do_txn("rand", w, a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        chk("protocol_errors", prot_err, 0);

        // slave never accepts AR: abort after TO cycles
        hang = 1'b1; ar0 = ar_hi; r0 = r_hs;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0, acc);
        get_rsp(acc, 0, lat, rd, rs, to);
        chk("to_lat", lat, TO + 1);
        chk("to_resp", rs, 2'b10);
        chk("to_flag", to, 1);
        chk("to_rdata", rd, 0);
        chk("to_arvalid_cycles", ar_hi - ar0, TO);
        chk("to_no_r", r_hs - r0, 0);
        hang = 1'b0;
        do_txn("post_to", 1'b1, 32'h0C, 32'h12345678, 4'hF, 0);
        chk("post_to_clear_on_accept", to_after_acc, 0);

        // reset while waiting for B
        b_dly = 10;
        send_cmd(1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, acc);
        repeat (2) @(negedge clk);
        chk("mid_bready", axi.bready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_axi", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        b_dly = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", cmd_ready, 1);
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (rsp_valid !== 1'b0) seen = 1'b1; end
        chk("mid_rst_no_rsp", seen, 0);

        // response held off for 5 cycles
        d = $urandom;
        do_txn("wr_stall", 1'b1, 32'h30, d, 4'hF, 0);
        do_txn("rd_stall", 1'b0, 32'h30, 32'h0, 4'h0, 5);
        chk("final_protocol_errors", prot_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
